// File: rtl/instr_prefetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit_pkg
//   Shared types and constants for the instruction prefetch unit.
//   - PKT_XLEN    : data/address width the fetch packet is built for
//   - INSTR_BYTES : size of one instruction word in bytes (PC stride)
//   - fetch_pkt_t : one buffered fetch, {instruction word, its PC}
// -----------------------------------------------------------------------------
package instr_prefetch_unit_pkg;

    localparam int PKT_XLEN    = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [PKT_XLEN-1:0] instr;
        logic [PKT_XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage : instr_prefetch_unit_pkg

// File: rtl/ipf_fifo.sv
// -----------------------------------------------------------------------------
// ipf_fifo
//   Synchronous FIFO with flush. The head word is read straight out of the
//   register array, so data_o is valid for the whole cycle after a push lands
//   (no write-to-read bypass).
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     flush_i          empties the FIFO; wins over a same-cycle push/pop
//     push_i, data_i   write one entry (ignored when full)
//     pop_i            drop the head entry (ignored when empty)
//     data_o           head entry
//     count_o          number of valid entries (0..DEPTH)
//     empty_o, full_o  occupancy flags
//   DEPTH must be a power of two (pointers wrap naturally) and >= 2.
// -----------------------------------------------------------------------------
module ipf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it was written, and leaving it out keeps the array as plain flops/RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : ipf_fifo

// File: rtl/instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit
//   Fetch front end: owns the PC, issues in-order word fetches to instruction
//   memory, buffers returned words and hands {instr, pc, npc} to decode.
//   A redirect from the memory stage flushes the buffer and discards every
//   fetch still in flight.
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     redirect_valid, redirect_pc        taken branch/jump target (bits[1:0] ignored)
//     imem_req_valid/ready/addr          fetch request handshake
//     imem_rsp_valid/data                in-order fetch responses
//     fd_valid/ready, fd_instr/pc/npc    decode handshake and payload
//   Build option PREFETCH_PERF_EN: adds perf_fetch_cnt (instructions popped by
//   decode) and perf_flush_cnt (redirects taken), both 32-bit wrapping.
//   XLEN must equal PKT_XLEN of the package (fetch_pkt_t is sized by it).
// -----------------------------------------------------------------------------
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = PKT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            fd_valid,
    input  logic            fd_ready,
    output logic [XLEN-1:0] fd_instr,
    output logic [XLEN-1:0] fd_pc,
    output logic [XLEN-1:0] fd_npc
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;  // in-flight / occupancy counters
    localparam int SW = CW + 1;             // sum of two such counters

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;  // all accepted, unanswered requests
    logic [CW-1:0]   drop_q, drop_d;                // oldest of those that are stale
    logic            req_en_q;                      // holds off fetching until after reset release

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_pkt_t      head;
    fetch_pkt_t      push_pkt;

    logic            req_fire;
    logic            rsp_live;
    logic            pop_fire;
    logic [CW-1:0]   live_inflight;
    logic [XLEN-1:0] rsp_pc;
    logic [SW-1:0]   credit_used;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits cover both buffered words and every request still in flight
    // (stale ones included), so a live response always finds a free slot.
    assign credit_used    = SW'(fifo_count) + SW'(outstanding_q);
    assign imem_req_valid = req_en_q && !redirect_valid && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are in order: the stale ones come first, and the response of a
    // live request is the oldest of the last (outstanding - drop) issued PCs.
    assign rsp_live      = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign live_inflight = outstanding_q - drop_q;
    assign rsp_pc        = pc_q - XLEN'({live_inflight, 2'b00});
    assign push_pkt      = '{instr: imem_rsp_data, pc: rsp_pc};

    assign fd_valid = !fifo_empty;
    assign pop_fire = fd_valid && fd_ready && !redirect_valid;
    assign fd_instr = fd_valid ? head.instr : '0;
    assign fd_pc    = fd_valid ? head.pc : '0;
    assign fd_npc   = fd_valid ? head.pc + XLEN'(INSTR_BYTES) : '0;

    ipf_fifo #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (rsp_live),
        .data_i  (push_pkt),
        .pop_i   (pop_fire),
        .data_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // NOTE: combinational next-state uses blocking '=' so later statements see
    // earlier results (drop_d reads outstanding_d); registers below use '<='.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            // No request is accepted this cycle; whatever is left in flight
            // after this cycle's response belongs to the old path.
            pc_d          = {redirect_pc[XLEN-1:2], 2'b00};
            outstanding_d = outstanding_q - CW'(imem_rsp_valid);
            drop_d        = outstanding_d;
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            req_en_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_en_q      <= 1'b1;
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q;
    logic [31:0] perf_flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            if (pop_fire)       perf_fetch_cnt_q <= perf_fetch_cnt_q + 32'd1;
            if (redirect_valid) perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`else
    // Performance counters not built.
`endif

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding_q == '0)));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_live && fifo_full));

endmodule : instr_prefetch_unit
